fsm_pattern_detector: RTL and testbench

Parametrised serial pattern-detector FSM, the generalised successor to the small fixed-encoding FSM examples in this benchmark set. The block accepts one qualified serial bit per cycle, tracks how many valid bits it holds, and emits a registered one-cycle match pulse whenever the last `W` accepted bits equal `PATTERN`. It also keeps a saturating match counter. It sits between a serial bit source with a valid qualifier and downstream control or statistics logic.

---
 rtl/fsm_pattern_detector.sv | 96 +++++++++
 tb/tb_fsm_pattern_detector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_detector.sv
// fsm_pattern_detector
//   Serial pattern detector. Accepts one qualified bit per cycle, shifts it
//   into a W-bit history window, and pulses `match` for one cycle when the
//   last W accepted bits equal PATTERN. It also keeps a saturating count of
//   matches.
//
//   State table (the FSM state is the partial-match depth `fill`):
//     fill    | meaning
//     0       | no valid history (after reset, clear or a non-overlap hit)
//     1..W-1  | partially filled window, no match possible yet
//     W       | window full, every accepted bit can complete a match
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset of all state
//   clear        synchronous clear; takes priority over x_valid
//   x_valid      qualifies x on this edge
//   x            serial data bit
//   match        registered one-cycle match pulse
//   match_count  saturating number of matches
//   fill         number of valid bits held, 0..W
//   window       history register, newest bit in the LSB
module fsm_pattern_detector #(
   parameter int unsigned   W       = 4,
   parameter logic [W-1:0]  PATTERN = 4'b1011,
   parameter bit            OVERLAP = 1'b1,
   parameter int unsigned   CNT_W   = 8,
   localparam int unsigned  FW      = $clog2(W + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             x_valid,
   input  logic             x,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic [FW-1:0]    fill,
   output logic [W-1:0]     window
);

   localparam logic [FW-1:0] FULL = FW'(W);

   logic [W-1:0]     nw;
   logic [FW-1:0]    nf;
   logic             hit;
   logic [W-1:0]     window_d;
   logic [FW-1:0]    fill_d;
   logic             match_d;
   logic [CNT_W-1:0] count_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         window      <= '0;
         fill        <= '0;
         match       <= 1'b0;
         match_count <= '0;
      end else begin
         window      <= window_d;
         fill        <= fill_d;
         match       <= match_d;
         match_count <= count_d;
      end
   end

   always_comb begin
      nw       = {window[W-2:0], x};
      nf       = (fill == FULL) ? FULL : fill + FW'(1);
      // A hit needs a full window of genuinely accepted bits, so a stale or
      // reset window can never match (matters for PATTERN = 0).
      hit      = (nf == FULL) && (nw == PATTERN);

      window_d = window;
      fill_d   = fill;
      match_d  = 1'b0;
      count_d  = match_count;

      if (clear) begin
         window_d = '0;
         fill_d   = '0;
         count_d  = '0;
      end else if (x_valid) begin
         window_d = nw;
         if (hit) begin
            match_d = 1'b1;
            // Without overlap the window keeps its bits but fill=0 masks
            // them, so the next match needs W fresh bits.
            fill_d  = OVERLAP ? FULL : '0;
            if (match_count != '1)
               count_d = match_count + CNT_W'(1);
         end else begin
            fill_d = nf;
         end
      end
   end

endmodule

// File: tb/tb_fsm_pattern_detector.sv
module tb_fsm_pattern_detector;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clear = 1'b0;
   logic x_valid = 1'b0;
   logic x = 1'b0;

   always #5 clk = ~clk;

   // Four configurations driven by the same stimulus:
   //   0: 1011 overlap, 1: 1011 no overlap, 2: 0000 overlap, 3: 1111 overlap CNT_W=2
   logic       m [4];
   logic [2:0] f [4];
   logic [3:0] w [4];
   logic [7:0] mc0, mc1, mc2;
   logic [1:0] mc3;

   fsm_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .x_valid(x_valid), .x(x),
      .match(m[0]), .match_count(mc0), .fill(f[0]), .window(w[0]));
   fsm_pattern_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .x_valid(x_valid), .x(x),
      .match(m[1]), .match_count(mc1), .fill(f[1]), .window(w[1]));
   fsm_pattern_detector #(.W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) u2 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .x_valid(x_valid), .x(x),
      .match(m[2]), .match_count(mc2), .fill(f[2]), .window(w[2]));
   fsm_pattern_detector #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u3 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .x_valid(x_valid), .x(x),
      .match(m[3]), .match_count(mc3), .fill(f[3]), .window(w[3]));

   // Reference model: history as an integer bit string, count of bits
   // accepted since the last restart, and plain saturating match counter.
   int pat  [4] = '{11, 11, 0, 15};
   int ovl  [4] = '{1, 0, 1, 1};
   int cmax [4] = '{255, 255, 255, 3};
   int hist [4];
   int since[4];
   int cnt  [4];
   int mexp [4];

   int total = 0;
   int fails = 0;

   task automatic chk(string tag, int cfg, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cfg%0d: observed %0d expected %0d", tag, cfg, obs, exp);
      end
   endtask

   function automatic logic [31:0] count_of(int cfg);
      case (cfg)
         0: count_of = 32'(mc0);
         1: count_of = 32'(mc1);
         2: count_of = 32'(mc2);
         default: count_of = 32'(mc3);
      endcase
   endfunction

   task automatic model_zero();
      for (int i = 0; i < 4; i++) begin
         hist[i] = 0; since[i] = 0; cnt[i] = 0; mexp[i] = 0;
      end
   endtask

   task automatic check_all(string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_match"}, i, 32'(m[i]), 32'(mexp[i]));
         chk({tag, "_count"}, i, count_of(i), 32'(cnt[i]));
         chk({tag, "_fill"},  i, 32'(f[i]), 32'(since[i] > 4 ? 4 : since[i]));
         chk({tag, "_window"}, i, 32'(w[i]), 32'(hist[i] & 15));
      end
   endtask

   // Drive one cycle, advance the model at the edge, check 1 time unit later.
   task automatic step(input logic v, input logic b, input logic c, input string tag);
      int nf;
      int nw;
      bit hit;
      x_valid = v; x = b; clear = c;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            hist[i] = 0; since[i] = 0; cnt[i] = 0; mexp[i] = 0;
         end else if (v) begin
            nw  = ((hist[i] << 1) | int'(b)) & 15;
            nf  = (since[i] + 1 > 4) ? 4 : since[i] + 1;
            hit = (nf == 4) && (nw == pat[i]);
            mexp[i] = hit ? 1 : 0;
            hist[i] = nw;
            if (hit) begin
               if (cnt[i] < cmax[i]) cnt[i]++;
               since[i] = ovl[i] ? 4 : 0;
            end else begin
               since[i] = nf;
            end
         end else begin
            mexp[i] = 0;
         end
      end
      #1;
      check_all(tag);
      x_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic bits(input string tag, input int n, input logic [15:0] seq);
      // seq holds n bits, first bit in position n-1
      for (int i = n - 1; i >= 0; i--) step(1'b1, seq[i], 1'b0, tag);
   endtask

   initial begin
      logic [15:0] s;
      model_zero();
      #12;
      check_all("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // Overlap vs non-overlap on 1,0,1,1,0,1,1
      s = 16'b1011011;
      bits("stream", 7, s);
      chk("ovl_count_const", 0, 32'(mc0), 32'd2);
      chk("ovl_fill_const", 0, 32'(f[0]), 32'd4);
      chk("novl_count_const", 1, 32'(mc1), 32'd1);
      chk("novl_fill_const", 1, 32'(f[1]), 32'd3);

      // All-zero pattern with idle gaps between valid bits
      step(1'b0, 1'b0, 1'b1, "clr");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, "zero");
         step(1'b0, 1'b0, 1'b0, "idle");
         step(1'b0, 1'b1, 1'b0, "idle");
      end
      step(1'b1, 1'b0, 1'b0, "zero4");
      chk("zero_match_const", 2, 32'(m[2]), 32'd1);
      step(1'b0, 1'b0, 1'b0, "zero_after");
      chk("zero_drop_const", 2, 32'(m[2]), 32'd0);

      // Saturation of the 2-bit counter on eight ones
      step(1'b0, 1'b0, 1'b1, "clr");
      s = 16'hFF;
      bits("ones", 8, s);
      chk("sat_const", 3, 32'(mc3), 32'd3);

      // Clear beats a valid bit, then a fresh match
      step(1'b0, 1'b0, 1'b1, "clr");
      s = 16'b101;
      bits("pre", 3, s);
      step(1'b1, 1'b1, 1'b1, "clr_valid");
      chk("clr_fill_const", 0, 32'(f[0]), 32'd0);
      s = 16'b1011;
      bits("post_clr", 4, s);
      chk("clr_match_const", 0, 32'(m[0]), 32'd1);

      // Asynchronous reset between edges
      s = 16'b101;
      bits("pre_rst", 3, s);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      model_zero();
      check_all("async_rst");
      #1;
      reset_n = 1'b1;
      s = 16'b1011;
      bits("post_rst", 4, s);
      chk("rst_match_const", 0, 32'(m[0]), 32'd1);

      // Random traffic with occasional clears
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(31) == 0), "rand");
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
